// File: rtl/cdb_arbiter.sv
// cdb_arbiter: holds one completed result per functional unit and arbitrates
// the held results onto CDB_SZ common-data-bus lanes each cycle. Any FU whose
// result is held but not granted is stalled.
// Build option: define CDB_ROUND_ROBIN_EN for rotating priority; otherwise the
// scan always starts at FU 0 (fixed priority, lowest index wins).

package cdb_arbiter_pkg;
    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] result;
    } FU_PACKET;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned CDB_SZ = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  FU_PACKET [NUM_FU-1:0]   fu_packs,
    input  logic     [NUM_FU-1:0]   fu_ready,
    output logic     [NUM_FU-1:0]   fu_stall,
    output FU_PACKET [CDB_SZ-1:0]   cdb_packets,
    output logic     [CDB_SZ-1:0]   cdb_valid
);

    localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned LANE_W = (CDB_SZ > 1) ? $clog2(CDB_SZ) : 1;

    logic     [NUM_FU-1:0] hold_valid;
    FU_PACKET [NUM_FU-1:0] hold_pkt;
    logic     [NUM_FU-1:0] grant;
    logic     [PTR_W-1:0]  scan_start;

`ifdef CDB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_next;

    assign scan_start = rr_ptr;

    // Priority pointer moves just past the last FU granted this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (!squash) begin
            rr_ptr <= rr_next;
        end
    end
`else
    assign scan_start = '0;
`endif

    // Scan held slots from scan_start, wrapping, granting up to CDB_SZ in order.
    always_comb begin
        int unsigned      idx;
        int unsigned      n_granted;
        logic [PTR_W-1:0] sel;
        logic [LANE_W-1:0] lane;
        grant       = '0;
        cdb_valid   = '0;
        cdb_packets = '0;
        n_granted   = 0;
        idx         = 0;
        sel         = '0;
        lane        = '0;
`ifdef CDB_ROUND_ROBIN_EN
        rr_next     = rr_ptr;
`endif
        if (!squash) begin
            for (int unsigned off = 0; off < NUM_FU; off++) begin
                idx = 32'(scan_start) + off;
                if (idx >= NUM_FU) begin
                    idx = idx - NUM_FU;
                end
                sel = PTR_W'(idx);
                if (hold_valid[sel] && (n_granted < CDB_SZ)) begin
                    lane              = LANE_W'(n_granted);
                    grant[sel]        = 1'b1;
                    cdb_valid[lane]   = 1'b1;
                    cdb_packets[lane] = hold_pkt[sel];
                    n_granted         = n_granted + 1;
`ifdef CDB_ROUND_ROBIN_EN
                    rr_next = (idx + 1 == NUM_FU) ? '0 : PTR_W'(idx + 1);
`endif
                end
            end
        end
    end

    // Stall depends only on registered state and the grant, never on fu_ready.
    assign fu_stall = hold_valid & ~grant;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
        // Skid slot: load when FU is not stalled, clear when drained, else hold.
        // A granted slot is not stalled, so it may reload on the same edge.
        always_ff @(posedge clock) begin
            if (reset) begin
                hold_valid[i] <= 1'b0;
                hold_pkt[i]   <= '0;
            end else if (squash) begin
                hold_valid[i] <= 1'b0;
            end else if (fu_ready[i] && !fu_stall[i]) begin
                hold_valid[i] <= 1'b1;
                hold_pkt[i]   <= fu_packs[i];
            end else if (grant[i]) begin
                hold_valid[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (NUM_FU=4, CDB_SZ=2).
// Expectations follow CDB_ROUND_ROBIN_EN when it is defined.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               squash;
    FU_PACKET [3:0]     fu_packs;
    logic     [3:0]     fu_ready;
    logic     [3:0]     fu_stall;
    FU_PACKET [1:0]     cdb_packets;
    logic     [1:0]     cdb_valid;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_FU(4), .CDB_SZ(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .fu_packs    (fu_packs),
        .fu_ready    (fu_ready),
        .fu_stall    (fu_stall),
        .cdb_packets (cdb_packets),
        .cdb_valid   (cdb_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic FU_PACKET pk(input logic [5:0] t);
        FU_PACKET p;
        p.tag    = t;
        p.result = 32'hC0DE_0000 | 32'(t);
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        squash   = 1'b0;
        fu_ready = '0;
        fu_packs = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        FU_PACKET [1:0] exp;
        reset  = 1'b1;
        squash = 1'b0;
        fu_ready = 4'b1111;
        for (int i = 0; i < 4; i++) fu_packs[i] = pk(6'(1 + i));
        tick();
        tick();
        checks++;
        if ({cdb_valid, fu_stall} !== 6'b00_0000 || cdb_packets !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b stall=%b pk=%h want 00 0000 0", cdb_valid, fu_stall, cdb_packets);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({cdb_valid, fu_stall} !== 6'b00_0000) begin
            errors++;
            $display("FAIL reset_release: valid=%b stall=%b want 00 0000", cdb_valid, fu_stall);
        end
        tick();
        fu_ready = '0;
        exp[0] = pk(6'd1);
        exp[1] = pk(6'd2);
        checks++;
        if (cdb_valid !== 2'b11 || cdb_packets !== exp || fu_stall !== 4'b1100) begin
            errors++;
            $display("FAIL reset_capture: valid=%b pk=%h stall=%b want 11 %h 1100", cdb_valid, cdb_packets, fu_stall, exp);
        end
        tick();
        exp[0] = pk(6'd3);
        exp[1] = pk(6'd4);
        checks++;
        if (cdb_valid !== 2'b11 || cdb_packets !== exp || fu_stall !== 4'b0000) begin
            errors++;
            $display("FAIL reset_drain: valid=%b pk=%h stall=%b want 11 %h 0000", cdb_valid, cdb_packets, fu_stall, exp);
        end
    endtask

    task automatic test_single();
        FU_PACKET [1:0] exp;
        do_reset();
        fu_ready    = 4'b0001;
        fu_packs[0] = pk(6'd5);
        tick();
        fu_ready = '0;
        exp[0] = pk(6'd5);
        exp[1] = '0;
        checks++;
        if (cdb_valid !== 2'b01 || cdb_packets !== exp || fu_stall !== 4'b0000) begin
            errors++;
            $display("FAIL single: valid=%b pk=%h stall=%b want 01 %h 0000", cdb_valid, cdb_packets, fu_stall, exp);
        end
        tick();
        checks++;
        if (cdb_valid !== 2'b00 || cdb_packets !== '0) begin
            errors++;
            $display("FAIL single_empty: valid=%b pk=%h want 00 0", cdb_valid, cdb_packets);
        end
    endtask

    task automatic test_oversub();
        FU_PACKET [1:0] exp;
        do_reset();
        fu_ready = 4'b1111;
        for (int i = 0; i < 4; i++) fu_packs[i] = pk(6'(10 + i));
        tick();
        // FU3 is stalled: a packet presented now is a violation and must be dropped
        fu_ready    = 4'b1000;
        fu_packs[3] = pk(6'd63);
        exp[0] = pk(6'd10);
        exp[1] = pk(6'd11);
        checks++;
        if (cdb_valid !== 2'b11 || cdb_packets !== exp || fu_stall !== 4'b1100) begin
            errors++;
            $display("FAIL oversub_c2: valid=%b pk=%h stall=%b want 11 %h 1100", cdb_valid, cdb_packets, fu_stall, exp);
        end
        tick();
        fu_ready = '0;
        exp[0] = pk(6'd12);
        exp[1] = pk(6'd13);
        checks++;
        if (cdb_valid !== 2'b11 || cdb_packets !== exp || fu_stall !== 4'b0000) begin
            errors++;
            $display("FAIL oversub_c3: valid=%b pk=%h stall=%b want 11 %h 0000", cdb_valid, cdb_packets, fu_stall, exp);
        end
        tick();
        checks++;
        if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000) begin
            errors++;
            $display("FAIL oversub_c4: valid=%b stall=%b want 00 0000", cdb_valid, fu_stall);
        end
        // pointer back at 0: a fresh burst on FUs 1,0 broadcasts 0 then 1
        fu_ready    = 4'b0011;
        fu_packs[0] = pk(6'd14);
        fu_packs[1] = pk(6'd15);
        tick();
        fu_ready = '0;
        exp[0] = pk(6'd14);
        exp[1] = pk(6'd15);
        checks++;
        if (cdb_valid !== 2'b11 || cdb_packets !== exp) begin
            errors++;
            $display("FAIL oversub_ptr: valid=%b pk=%h want 11 %h", cdb_valid, cdb_packets, exp);
        end
    endtask

    task automatic test_back_to_back();
        FU_PACKET [1:0] exp;
        do_reset();
        fu_ready = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            fu_packs[0] = pk(6'(20 + c));
            tick();
            exp[0] = pk(6'(20 + c));
            exp[1] = '0;
            checks++;
            if (cdb_valid !== 2'b01 || cdb_packets !== exp || fu_stall !== 4'b0000) begin
                errors++;
                $display("FAIL back_to_back[%0d]: valid=%b pk=%h stall=%b want 01 %h 0000", c, cdb_valid, cdb_packets, fu_stall, exp);
            end
        end
        fu_ready = '0;
        tick();
        checks++;
        if (cdb_valid !== 2'b00) begin
            errors++;
            $display("FAIL back_to_back_end: valid=%b want 00", cdb_valid);
        end
    endtask

    task automatic test_squash();
        do_reset();
        fu_ready    = 4'b1100;
        fu_packs[2] = pk(6'd32);
        fu_packs[3] = pk(6'd33);
        tick();
        squash      = 1'b1;
        fu_ready    = 4'b0010;
        fu_packs[1] = pk(6'd31);
        #1;
        checks++;
        if (cdb_valid !== 2'b00 || cdb_packets !== '0 || fu_stall !== 4'b1100) begin
            errors++;
            $display("FAIL squash_cycle: valid=%b pk=%h stall=%b want 00 0 1100", cdb_valid, cdb_packets, fu_stall);
        end
        tick();
        squash   = 1'b0;
        fu_ready = '0;
        #1;
        checks++;
        if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000) begin
            errors++;
            $display("FAIL squash_after: valid=%b stall=%b want 00 0000", cdb_valid, fu_stall);
        end
        tick();
        checks++;
        if (cdb_valid !== 2'b00) begin
            errors++;
            $display("FAIL squash_after2: valid=%b want 00", cdb_valid);
        end
    endtask

    task automatic test_reset_mid();
        FU_PACKET [1:0] exp;
        do_reset();
        fu_ready = 4'b1111;
        for (int i = 0; i < 4; i++) fu_packs[i] = pk(6'(50 + i));
        tick();
        reset  = 1'b1;
        squash = 1'b1;
        tick();
        checks++;
        if (cdb_valid !== 2'b00 || cdb_packets !== '0 || fu_stall !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: valid=%b pk=%h stall=%b want 00 0 0000", cdb_valid, cdb_packets, fu_stall);
        end
        reset  = 1'b0;
        squash = 1'b0;
        tick();
        fu_ready = '0;
        exp[0] = pk(6'd50);
        exp[1] = pk(6'd51);
        checks++;
        if (cdb_valid !== 2'b11 || cdb_packets !== exp || fu_stall !== 4'b1100) begin
            errors++;
            $display("FAIL reset_mid_resume: valid=%b pk=%h stall=%b want 11 %h 1100", cdb_valid, cdb_packets, fu_stall, exp);
        end
    endtask

    task automatic test_fairness();
        FU_PACKET [1:0] exp;
        logic [3:0] exp_stall;
        do_reset();
        fu_ready = 4'b1111;
        for (int i = 0; i < 4; i++) fu_packs[i] = pk(6'(40 + i));
        tick();
        for (int c = 0; c < 6; c++) begin
            exp[0] = pk(6'd40);
            exp[1] = pk(6'd41);
            exp_stall = 4'b1100;
`ifdef CDB_ROUND_ROBIN_EN
            if ((c % 2) == 1) begin
                exp[0] = pk(6'd42);
                exp[1] = pk(6'd43);
                exp_stall = 4'b0011;
            end
`endif
            checks++;
            if (cdb_valid !== 2'b11 || cdb_packets !== exp || fu_stall !== exp_stall) begin
                errors++;
                $display("FAIL fairness[%0d]: valid=%b pk=%h stall=%b want 11 %h %b", c, cdb_valid, cdb_packets, fu_stall, exp, exp_stall);
            end
            tick();
        end
        fu_ready = '0;
    endtask

    initial begin
        reset    = 1'b1;
        squash   = 1'b0;
        fu_ready = '0;
        fu_packs = '0;
        test_reset();
        test_single();
        test_oversub();
        test_back_to_back();
        test_squash();
        test_reset_mid();
        test_fairness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-side consumer of the functional-unit result interface: each FU (mult, ALU, branch, load) presents an `FU_PACKET` with a `data_ready` strobe and receives a `stall` back. The block holds one completed result per FU in a skid register, arbitrates held results onto `CDB_SZ` common-data-bus lanes each cycle, and back-pressures any FU whose result is waiting. It sits between the FU outputs and the CDB broadcast to RS/ROB/map table.

## Interface
- `NUM_FU`, default 4: number of FU result ports.
- `CDB_SZ`, default 2: CDB lanes per cycle; legal range 1..`NUM_FU`.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `squash`  in  1  mispredict flush; drops all held and incoming results.
- `fu_packs`  in  `NUM_FU` x `FU_PACKET`  result from each FU.
- `fu_ready`  in  `NUM_FU`  per-FU `data_ready`; packet valid this cycle.
- `fu_stall`  out  `NUM_FU`  per-FU stall; FU must freeze its pipeline and hold its output.
- `cdb_packets`  out  `CDB_SZ` x `FU_PACKET`  broadcast results.
- `cdb_valid`  out  `CDB_SZ`  lane valid.

## Operation
- State: per-FU `hold_valid[i]`, `hold_pkt[i]`; priority pointer `rr_ptr` ($clog2(`NUM_FU`) bits).
- Grant (combinational, from registered state only): scan FU indices starting at `rr_ptr`, wrapping modulo `NUM_FU`; the first `CDB_SZ` indices with `hold_valid` set are granted, in scan order onto lanes 0,1,...
- Lane k: `cdb_valid[k]`=1, `cdb_packets[k]`=`hold_pkt` of the k-th grant; unused lanes drive valid 0 and packet all-zero.
- `fu_stall[i] = hold_valid[i] & ~grant[i]`. No combinational path from `fu_ready` to `fu_stall` (FU gates `data_ready` with `~stall`).
- Slot update per FU at posedge: if `fu_ready[i]` & ~`fu_stall[i]` -> load `fu_packs[i]`, set valid; else if granted -> clear valid; else hold.
- Granted slot may reload the same edge (full throughput of one result per FU per cycle).
- `fu_ready[i]` while `fu_stall[i]`=1 is a protocol violation; packet ignored, slot unchanged.
- `rr_ptr` update: if any grant, becomes (index of last granted FU + 1) mod `NUM_FU`; else unchanged.
- `squash`: `cdb_valid` forced to 0 that cycle; at posedge all `hold_valid` clear, incoming `fu_ready` packets dropped, `rr_ptr` unchanged; `fu_stall` still computed from state (no grants -> all held FUs stalled for that cycle).

## Timing
- Reset values: all `hold_valid`=0, `rr_ptr`=0, `cdb_valid`=0, `cdb_packets`=0, `fu_stall`=0.
- Latency: `fu_ready` at cycle N -> result on CDB cycle N+1 earliest.
- With ≤`CDB_SZ` held results, all broadcast in one cycle, no stalls.
- With more than `CDB_SZ` held, losers stall; an FU waits at most ceil(`NUM_FU`/`CDB_SZ`)-1 cycles under round-robin.
- Reset asserted mid-operation overrides squash and fu_ready; outputs reach reset values the following cycle.

## Configuration
- `CDB_ROUND_ROBIN_EN` defined: rotating priority as above.
- Not defined: fixed priority, scan always starts at index 0 (lowest FU wins); `rr_ptr` absent/constant 0. Starvation of high indices permitted.

## Test plan
- Reset: hold `reset` 2 cycles with all `fu_ready`=1 -> after release, `cdb_valid`=00, `fu_stall`=0000; first edge after release captures packets.
- Single result: `fu_ready`=0001 pkt tag 5 at cycle 1 -> cycle 2 `cdb_valid`=01, lane 0 tag 5, no stall.
- Oversubscription (`NUM_FU`=4,`CDB_SZ`=2): all four ready cycle 1, tags 10..13 -> cycle 2 lanes {10,11}, `fu_stall`=1100; cycle 3 lanes {12,13}, `fu_stall`=0000, `rr_ptr`=0.
- Back-to-back: FU0 ready every cycle, others idle -> tag on CDB each cycle one later, `fu_stall[0]` never asserts.
- Squash: FUs 2,3 held and FU1 ready, `squash`=1 -> `cdb_valid`=00 that cycle; next cycle all slots empty, nothing broadcast.
- Fairness: all FUs ready continuously -> with macro each FU granted every 2 cycles; without macro FUs 0,1 granted each cycle and `fu_stall[3:2]`=11 persistently.
